// File: rtl/tt_count_pkg.sv
// Shared definitions for the counter UART transmitter.
//   - default CLKS_PER_BIT and DATA_W values
//   - FSM state encoding (ST_IDLE..ST_STOP) and the typed state enum built on it
package tt_count_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;
    localparam int unsigned DEFAULT_DATA_W       = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        StIdle   = ST_IDLE,
        StStart  = ST_START,
        StData   = ST_DATA,
        StParity = ST_PARITY,
        StStop   = ST_STOP
    } state_e;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer for the UART transmitter.
//   i_clk      : clock
//   i_rst      : asynchronous active-high reset
//   i_restart  : hold the counter at zero (transmitter idle)
//   o_bit_end  : high in the last cycle of each CLKS_PER_BIT-cycle bit period
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_bit_end
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Counter wraps at the end of every bit, so each state change starts from zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == LAST_CNT)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_bit_end = !i_restart && (r_cnt == LAST_CNT);

endmodule

// File: rtl/count_uart_tx.sv
// Snapshots the counter value on a send request and serialises it as a UART frame:
// start(0), DATA_W data bits LSB-first, optional even parity, stop(1).
//   i_clk       : clock
//   i_rst       : asynchronous active-high reset
//   i_count_in  : counter value to transmit
//   i_send      : transmit request, sampled every cycle
//   i_clear_ovr : clears the overrun flag
//   o_tx        : serial line, idles high
//   o_busy      : frame in progress
//   o_done      : one-cycle pulse after the stop bit ends
//   o_overrun   : sticky, a send arrived while busy
module count_uart_tx
    import tt_count_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_W       = DEFAULT_DATA_W,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_count_in,
    input  logic              i_send,
    input  logic              i_clear_ovr,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun
);

    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_e            r_state, w_state_next;
    logic [DATA_W-1:0] r_shift, w_shift_next;
    logic [IDX_W-1:0]  r_idx, w_idx_next;
    logic              r_parity, w_parity_next;
    logic              r_done, w_done_next;
    logic              r_overrun, w_overrun_next;
    logic              w_bit_end;
    logic              w_busy;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_restart(r_state == StIdle),
        .o_bit_end(w_bit_end)
    );

    assign w_busy = (r_state != StIdle);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_shift   <= '0;
            r_idx     <= '0;
            r_parity  <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_idx     <= w_idx_next;
            r_parity  <= w_parity_next;
            r_done    <= w_done_next;
            r_overrun <= w_overrun_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_idx_next     = r_idx;
        w_parity_next  = r_parity;
        w_done_next    = 1'b0;
        w_overrun_next = r_overrun;
        o_tx           = 1'b1;

        unique case (r_state)
            StIdle: begin
                if (i_send) begin
                    // Parity is taken from the snapshot since the shift register is consumed.
                    w_shift_next  = i_count_in;
                    w_parity_next = ^i_count_in;
                    w_state_next  = StStart;
                end
            end
            StStart: begin
                o_tx = 1'b0;
                if (w_bit_end) begin
                    w_state_next = StData;
                end
            end
            StData: begin
                o_tx = r_shift[0];
                if (w_bit_end) begin
                    w_shift_next = r_shift >> 1;
                    if (r_idx == LAST_IDX) begin
                        w_idx_next   = '0;
                        w_state_next = PARITY_EN ? StParity : StStop;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end
            StParity: begin
                o_tx = r_parity;
                if (w_bit_end) begin
                    w_state_next = StStop;
                end
            end
            StStop: begin
                if (w_bit_end) begin
                    w_state_next = StIdle;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        // A set in the same cycle as a clear takes priority.
        if (i_send && w_busy) begin
            w_overrun_next = 1'b1;
        end else if (i_clear_ovr) begin
            w_overrun_next = 1'b0;
        end
    end

    assign o_busy    = w_busy;
    assign o_done    = r_done;
    assign o_overrun = r_overrun;

endmodule

// File: tb/tb_count_uart_tx.sv
// Bench for count_uart_tx with CLKS_PER_BIT=4: table-driven frame checks on a plain and a
// parity instance, hand-written corner sequences, then random traffic against a frame model.
module tb_count_uart_tx;

    localparam int CPB = 4;

    typedef struct {
        logic [7:0]  data;
        logic        par;
        logic [10:0] frame;     // frame[i] = i-th transmitted bit, start bit first
        int          done_cyc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] count_in;
    logic       send0, send1, clear_ovr;
    logic       tx0, busy0, done0, ovr0;
    logic       tx1, busy1, done1, ovr1;

    int checks   = 0;
    int failures = 0;

    vec_t tbl[6];

    always #5 clk = ~clk;

    count_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (8),
        .PARITY_EN   (1'b0)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_count_in (count_in),
        .i_send     (send0),
        .i_clear_ovr(clear_ovr),
        .o_tx       (tx0),
        .o_busy     (busy0),
        .o_done     (done0),
        .o_overrun  (ovr0)
    );

    count_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (8),
        .PARITY_EN   (1'b1)
    ) dut_p (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_count_in (count_in),
        .i_send     (send1),
        .i_clear_ovr(clear_ovr),
        .o_tx       (tx1),
        .o_busy     (busy1),
        .o_done     (done1),
        .o_overrun  (ovr1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40) begin
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy0 || busy1) && n < 100) begin
            step();
            n++;
        end
        check("idle_timeout", {30'd0, busy0, busy1}, 32'd0);
    endtask

    // Sends one frame and checks every cycle up to the done pulse. Optional extras: a send
    // pulse at ovr_cyc while busy, a count_in change at chg_cyc, a send in the done cycle.
    task automatic run_frame(input vec_t v, input int ovr_cyc, input int chg_cyc,
                             input bit b2b);
        logic tx_s, busy_s, done_s, ovr_s, exp_tx;
        wait_idle();
        count_in = v.data;
        if (v.par) send1 = 1'b1; else send0 = 1'b1;
        step();  // edge 0 sampled send; now in cycle 1
        send0 = 1'b0;
        send1 = 1'b0;
        for (int cyc = 1; cyc <= v.done_cyc; cyc++) begin
            tx_s   = v.par ? tx1 : tx0;
            busy_s = v.par ? busy1 : busy0;
            done_s = v.par ? done1 : done0;
            ovr_s  = v.par ? ovr1 : ovr0;
            exp_tx = (cyc < v.done_cyc) ? v.frame[(cyc - 1) / CPB] : 1'b1;
            check("frame_tx", {31'd0, tx_s}, {31'd0, exp_tx});
            check("frame_busy", {31'd0, busy_s}, {31'd0, cyc < v.done_cyc});
            check("frame_done", {31'd0, done_s}, {31'd0, cyc == v.done_cyc});
            check("frame_ovr", {31'd0, ovr_s}, {31'd0, (ovr_cyc > 0) && (cyc > ovr_cyc)});
            if (cyc + 1 == chg_cyc) count_in = 8'hFF;
            if ((cyc == ovr_cyc) || (b2b && cyc == v.done_cyc)) begin
                if (v.par) send1 = 1'b1; else send0 = 1'b1;
            end
            step();
            send0 = 1'b0;
            send1 = 1'b0;
        end
        if (b2b) begin
            check("b2b_start_tx", {31'd0, v.par ? tx1 : tx0}, 32'd0);
            check("b2b_busy", {31'd0, v.par ? busy1 : busy0}, 32'd1);
        end
    endtask

    // Reference model for the random phase: a queue of per-cycle line values.
    bit m_q[$];
    bit m_done, m_ovr;

    initial begin
        tbl[0] = '{data: 8'hA5, par: 1'b0, frame: 11'b01101001010, done_cyc: 41};
        tbl[1] = '{data: 8'h3C, par: 1'b0, frame: 11'b01001111000, done_cyc: 41};
        tbl[2] = '{data: 8'h00, par: 1'b0, frame: 11'b01000000000, done_cyc: 41};
        tbl[3] = '{data: 8'h07, par: 1'b1, frame: 11'b11000001110, done_cyc: 45};
        tbl[4] = '{data: 8'hFF, par: 1'b1, frame: 11'b10111111110, done_cyc: 45};
        tbl[5] = '{data: 8'h5A, par: 1'b0, frame: 11'b01010110100, done_cyc: 41};

        rst = 1'b1;
        count_in = 8'h00;
        send0 = 1'b0;
        send1 = 1'b0;
        clear_ovr = 1'b0;
        repeat (2) step();
        check("rst_tx", {30'd0, tx0, tx1}, 32'd3);
        check("rst_busy", {30'd0, busy0, busy1}, 32'd0);
        check("rst_done", {30'd0, done0, done1}, 32'd0);
        check("rst_ovr", {30'd0, ovr0, ovr1}, 32'd0);
        rst = 1'b0;
        step();
        check("idle_tx", {30'd0, tx0, tx1}, 32'd3);

        // Basic frame, then each table entry.
        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i], 0, 0, 1'b0);
        end

        // Overrun: send during a frame, then clear it.
        run_frame(tbl[0], 10, 0, 1'b0);
        check("ovr_sticky", {31'd0, ovr0}, 32'd1);
        clear_ovr = 1'b1;
        step();
        clear_ovr = 1'b0;
        check("ovr_cleared", {31'd0, ovr0}, 32'd0);

        // Snapshot: count_in moves to 0xFF at cycle 5, frame still carries 0x3C.
        run_frame(tbl[1], 0, 5, 1'b0);

        // Back-to-back: send in the done cycle.
        run_frame(tbl[2], 0, 0, 1'b1);
        wait_idle();

        // Mid-frame reset during data bit 3 (cycles 17..20).
        count_in = 8'hA5;
        send0 = 1'b1;
        step();
        send0 = 1'b0;
        repeat (17) step();
        check("pre_rst_bit3", {31'd0, tx0}, 32'd0);
        check("pre_rst_busy", {31'd0, busy0}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_tx", {31'd0, tx0}, 32'd1);
        check("async_rst_busy", {31'd0, busy0}, 32'd0);
        step();
        rst = 1'b0;
        run_frame(tbl[5], 0, 0, 1'b0);

        // Random traffic on the plain instance against the queue model.
        wait_idle();
        clear_ovr = 1'b1;
        step();
        clear_ovr = 1'b0;
        m_ovr = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            send0 = ($urandom_range(0, 7) == 0);
            clear_ovr = ($urandom_range(0, 15) == 0);
            count_in = 8'($urandom);
            @(posedge clk);
            m_done = 1'b0;
            if (m_q.size() != 0 && send0) m_ovr = 1'b1;
            else if (clear_ovr) m_ovr = 1'b0;
            if (m_q.size() != 0) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1'b1;
            end else if (send0) begin
                for (int k = 0; k < CPB; k++) m_q.push_back(1'b0);
                for (int b = 0; b < 8; b++) begin
                    for (int k = 0; k < CPB; k++) m_q.push_back(count_in[b]);
                end
                for (int k = 0; k < CPB; k++) m_q.push_back(1'b1);
            end
            #1;
            check("rnd_tx", {31'd0, tx0}, {31'd0, (m_q.size() != 0) ? m_q[0] : 1'b1});
            check("rnd_busy", {31'd0, busy0}, {31'd0, m_q.size() != 0});
            check("rnd_done", {31'd0, done0}, {31'd0, m_done});
            check("rnd_ovr", {31'd0, ovr0}, {31'd0, m_ovr});
        end
        send0 = 1'b0;
        clear_ovr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
